pio_key_capture: RTL

PIO_KEY_CAPTURE -- requirements
Module: pio_key_capture

---
 rtl/pio_pkg.sv | 22 ++
 rtl/pio_debounce.sv | 37 +++
 rtl/pio_key_capture.sv | 104 ++++++++++
 3 files changed

// File: rtl/pio_pkg.sv
// Shared constants for the PIO key-capture block: register word addresses and edge selectors.
package pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Per-bit edge event from the current filtered value and its one-cycle-old copy.
    function automatic logic edge_event(input int edge_type, input logic f, input logic fp);
        case (edge_type)
            EDGE_RISE: return f & ~fp;
            EDGE_FALL: return ~f & fp;
            default:   return f ^ fp;
        endcase
    endfunction

endpackage

// File: rtl/pio_debounce.sv
// One-bit debouncer: the output follows the synchronized input only after it has
// disagreed with the output for DEBOUNCE_CYCLES consecutive clocks.
module pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_sync,
    output logic o_filt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_filt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (i_sync != r_filt) begin
            if (r_cnt == LAST) begin
                r_filt <= i_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            // Any return to agreement throws away the partial count.
            r_cnt <= '0;
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/pio_key_capture.sv
// Avalon-MM key/switch input port with sticky edge capture and masked level interrupt.
// Optional per-bit debounce is compiled in when PIO_KEY_DEBOUNCE_EN is defined.
module pio_key_capture
    import pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_fp;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;

    logic [WIDTH-1:0] w_f;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clear;
    logic             w_wr;
    logic             w_unused_wdata;

    // Only the low WIDTH bits of writedata carry meaning.
    assign w_unused_wdata = ^writedata;

    assign w_wr = chipselect && !write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
        end
    end

`ifdef PIO_KEY_DEBOUNCE_EN
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_db
            pio_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk    (clk),
                .reset_n(reset_n),
                .i_sync (r_s2[gi]),
                .o_filt (w_f[gi])
            );
        end
    endgenerate
`else
    assign w_f = r_s2;
`endif

    genvar ge;
    generate
        for (ge = 0; ge < WIDTH; ge++) begin : g_edge
            assign w_event[ge] = edge_event(EDGE_TYPE, w_f[ge], r_fp[ge]);
        end
    endgenerate

    assign w_clear = (w_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fp      <= '0;
            r_irqmask <= '0;
            r_edgecap <= '0;
        end else begin
            r_fp <= w_f;
            if (w_wr && address == ADDR_IRQMASK) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            // OR-ing the event after the clear lets a simultaneous edge win.
            r_edgecap <= (r_edgecap & ~w_clear) | w_event;
        end
    end

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                ADDR_DATA:    readdata[WIDTH-1:0] = w_f;
                ADDR_IRQMASK: readdata[WIDTH-1:0] = r_irqmask;
                ADDR_EDGECAP: readdata[WIDTH-1:0] = r_edgecap;
                default:      readdata = '0;
            endcase
        end
    end

    assign irq = |(r_edgecap & r_irqmask);

endmodule
